uart_receiver: RTL and testbench

Serial-to-parallel receiver for the single-wire 8N1 link driven by the project's `transmitter` block. It samples the `RXD` line, recovers start / 8 data / stop framing and presents each byte on a registered output with a valid/ack handshake. It also flags framing errors and overruns. It sits on the receive side of the link, facing the byte consumer.

---
 rtl/uart_receiver.sv | 181 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver for the transmitter link.
// RXD is synchronized, the frame is sampled near bit centres, and each good
// byte is presented on a registered valid/ack interface. Stop-bit failures
// raise frame_err; good bytes that cannot be stored raise overrun.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RXD,
    output logic [0:7] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF > 0) ? (HALF - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [0:7]       shift_q, shift_d;
    logic [0:7]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             rxd_s;
    logic             done_s;

    assign rxd_s     = sync2_q;
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = busy_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

    // Next-state logic: synchronizer, frame FSM, and the byte handshake.
    always_comb begin
        sync1_d = RXD;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        done_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rxd_s == 1'b0) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    // With no half-bit delay the start check lands on t0 itself.
                    if (HALF == 0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_START;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    if (rxd_s == 1'b1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxd_s;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s == 1'b1) begin
                        done_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BREAK: begin
                if (rxd_s == 1'b1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A completing byte wins over a plain ack; an ack in the same cycle frees the slot.
        if (done_s) begin
            if (!valid_q || rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ack) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: two instances (1 and 4 clocks per bit) share one
// line waveform. A frame-level reference model predicts every output per cycle.
module tb_uart_receiver;

    localparam int MAXC = 600;

    logic       clk;
    logic       reset;
    logic       RXD;
    logic       rx_ack;
    logic [0:7] o_data  [2];
    logic       o_valid [2];
    logic       o_busy  [2];
    logic       o_ferr  [2];
    logic       o_ovr   [2];

    int total;
    int bad;

    // Scenario stimulus: one entry per clock cycle; cycle 0 is a reset cycle.
    logic line_a [MAXC];
    logic ack_a  [MAXC];
    int   n_cyc;

    // Model scratch and expected values (index = cycle in which value is visible).
    logic       m_busy [MAXC];
    logic       m_fe   [MAXC];
    logic       m_comp [MAXC];
    logic [0:7] m_byte [MAXC];
    logic       e_valid [2][MAXC];
    logic [0:7] e_data  [2][MAXC];
    logic       e_busy  [2][MAXC];
    logic       e_fe    [2][MAXC];
    logic       e_ov    [2][MAXC];

    int lb_t;
    int lb_first;
    bit lb_track;

    uart_receiver #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .RXD(RXD),
        .rx_data(o_data[0]), .rx_valid(o_valid[0]), .rx_ack(rx_ack),
        .rx_busy(o_busy[0]), .frame_err(o_ferr[0]), .overrun(o_ovr[0])
    );

    uart_receiver #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .reset(reset), .RXD(RXD),
        .rx_data(o_data[1]), .rx_valid(o_valid[1]), .rx_ack(rx_ack),
        .rx_busy(o_busy[1]), .frame_err(o_ferr[1]), .overrun(o_ovr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(logic b, logic a);
        line_a[n_cyc] = b;
        ack_a[n_cyc]  = a;
        n_cyc++;
    endfunction

    function automatic void idle(int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b0);
    endfunction

    function automatic void begin_scenario();
        n_cyc = 0;
        push(1'b1, 1'b0);
    endfunction

    // Pushes one frame of w cycles per bit; returns the cycle of its start bit.
    function automatic int frame(logic [0:7] d, logic stop_bit, int w);
        int s;
        s = n_cyc;
        for (int i = 0; i < w; i++) push(1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < w; i++) push(d[k], 1'b0);
        for (int i = 0; i < w; i++) push(stop_bit, 1'b0);
        return s;
    endfunction

    function automatic void mark(int a, int b);
        for (int t = a; t <= b; t++)
            if (t >= 0 && t < n_cyc) m_busy[t] = 1'b1;
    endfunction

    // Frame-level model: line cycle p first low, t0 = p+2, samples at fixed offsets.
    function automatic void build_model(int i, int cpb);
        int h, p, s_line, s_cyc, q;
        bit done;
        logic valid, ov;
        logic [0:7] data, b;
        h = (cpb - 1) / 2;
        for (int t = 0; t < MAXC; t++) begin
            m_busy[t] = 1'b0; m_fe[t] = 1'b0; m_comp[t] = 1'b0; m_byte[t] = 8'h00;
        end
        p = 1;
        done = 1'b0;
        while (!done && p < n_cyc) begin
            if (line_a[p] == 1'b1) begin
                p++;
            end else if (h > 0 && p + h >= n_cyc) begin
                mark(p + 3, n_cyc - 1);
                done = 1'b1;
            end else if (h > 0 && line_a[p + h] == 1'b1) begin
                mark(p + 3, p + 2 + h);
                p = p + h + 1;
            end else begin
                s_line = p + h + 9 * cpb;
                s_cyc  = s_line + 2;
                if (s_line >= n_cyc) begin
                    mark(p + 3, n_cyc - 1);
                    done = 1'b1;
                end else begin
                    for (int k = 0; k < 8; k++) b[k] = line_a[p + h + cpb * (k + 1)];
                    mark(p + 3, s_cyc);
                    if (line_a[s_line] == 1'b1) begin
                        if (s_cyc < n_cyc) begin
                            m_comp[s_cyc] = 1'b1;
                            m_byte[s_cyc] = b;
                        end
                        p = s_line + 1;
                    end else begin
                        if (s_cyc + 1 < n_cyc) m_fe[s_cyc + 1] = 1'b1;
                        q = s_line + 1;
                        while (q < n_cyc && line_a[q] == 1'b0) q++;
                        if (q >= n_cyc) begin
                            mark(s_cyc + 1, n_cyc - 1);
                            done = 1'b1;
                        end else begin
                            mark(s_cyc + 1, q + 2);
                            p = q + 1;
                        end
                    end
                end
            end
        end
        valid = 1'b0; data = 8'h00; ov = 1'b0;
        for (int t = 1; t < n_cyc; t++) begin
            e_valid[i][t] = valid;
            e_data[i][t]  = data;
            e_ov[i][t]    = ov;
            e_fe[i][t]    = m_fe[t];
            e_busy[i][t]  = m_busy[t];
            ov = 1'b0;
            if (m_comp[t]) begin
                if (!valid || ack_a[t]) begin
                    data  = m_byte[t];
                    valid = 1'b1;
                end else begin
                    ov = 1'b1;
                end
            end else if (valid && ack_a[t]) begin
                valid = 1'b0;
            end
        end
    endfunction

    task automatic chk(input string tag, input int t, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic run_scenario(input string name);
        build_model(0, 1);
        build_model(1, 4);
        for (int t = 0; t < n_cyc; t++) begin
            reset  = (t == 0);
            RXD    = line_a[t];
            rx_ack = ack_a[t];
            @(posedge clk);
            #1;
            if (t + 1 < n_cyc) begin
                for (int i = 0; i < 2; i++) begin
                    chk({name, (i == 0) ? ".c1" : ".c4", ".rx_valid"}, t + 1, {7'd0, o_valid[i]}, {7'd0, e_valid[i][t + 1]});
                    chk({name, (i == 0) ? ".c1" : ".c4", ".rx_data"},  t + 1, o_data[i], e_data[i][t + 1]);
                    chk({name, (i == 0) ? ".c1" : ".c4", ".rx_busy"},  t + 1, {7'd0, o_busy[i]}, {7'd0, e_busy[i][t + 1]});
                    chk({name, (i == 0) ? ".c1" : ".c4", ".frame_err"}, t + 1, {7'd0, o_ferr[i]}, {7'd0, e_fe[i][t + 1]});
                    chk({name, (i == 0) ? ".c1" : ".c4", ".overrun"},  t + 1, {7'd0, o_ovr[i]}, {7'd0, e_ov[i][t + 1]});
                end
                if (lb_track && lb_first < 0 && o_valid[0] === 1'b1) lb_first = t + 1;
            end
        end
    endtask

    initial begin
        int p1, p2, w, ng;
        logic [0:7] rb;
        logic sb;
        total = 0;
        bad = 0;
        reset = 1'b1;
        RXD = 1'b1;
        rx_ack = 1'b0;
        lb_track = 1'b0;
        lb_first = -1;

        // Loopback byte 1010_0011, ack well after delivery.
        begin_scenario();
        idle(4);
        lb_t = frame(8'b1010_0011, 1'b1, 1);
        idle(25);
        ack_a[lb_t + 20] = 1'b1;
        lb_track = 1'b1;
        run_scenario("loopback");
        lb_track = 1'b0;
        total++;
        assert (lb_first === lb_t + 12) else begin
            bad++;
            $error("FAIL loopback.valid_rise observed=%0d expected=%0d", lb_first, lb_t + 12);
        end

        // One-cycle low glitch.
        begin_scenario();
        idle(4);
        push(1'b0, 1'b0);
        idle(30);
        run_scenario("glitch");

        // Framing error followed by a good frame.
        begin_scenario();
        idle(3);
        p1 = frame(8'h5A, 1'b0, 1);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0);
        idle(5);
        p2 = frame(8'h3C, 1'b1, 1);
        idle(15);
        run_scenario("frame_err");

        // Overrun: two back-to-back frames, never acked.
        begin_scenario();
        idle(3);
        p1 = frame(8'h11, 1'b1, 1);
        p2 = frame(8'h22, 1'b1, 1);
        idle(15);
        run_scenario("overrun");

        // Same pair, ack exactly in the second stop-sample cycle.
        begin_scenario();
        idle(3);
        p1 = frame(8'h11, 1'b1, 1);
        p2 = frame(8'h22, 1'b1, 1);
        idle(15);
        ack_a[p2 + 11] = 1'b1;
        run_scenario("ack_at_stop");

        // Reset during data bit 4 of 0xFF, then a clean 0x81.
        begin_scenario();
        idle(3);
        p1 = frame(8'hFF, 1'b1, 1);
        n_cyc = p1 + 7;
        run_scenario("pre_reset");
        begin_scenario();
        idle(4);
        p2 = frame(8'h81, 1'b1, 1);
        idle(15);
        run_scenario("post_reset");

        // Randomized traffic at both bit widths with random acks.
        for (int s = 0; s < 3; s++) begin
            begin_scenario();
            idle(3);
            for (int f = 0; f < 6; f++) begin
                w  = ($urandom_range(0, 1) == 0) ? 1 : 4;
                rb = 8'($urandom);
                sb = ($urandom_range(0, 5) != 0);
                p1 = frame(rb, sb, w);
                if (!sb) begin
                    ng = $urandom_range(0, 3);
                    for (int i = 0; i < ng; i++) push(1'b0, 1'b0);
                end
                idle($urandom_range(0, 12));
            end
            idle(50);
            for (int t = 1; t < n_cyc; t++) ack_a[t] = ($urandom_range(0, 2) == 0);
            run_scenario("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
